// File: rtl/stack_pipe_controller_pkg.sv
// Shared opcodes, mux_sel bit positions and the decoded-control bundle
// for the two-stage stack controller.
package stack_pipe_pkg;

  localparam logic [3:0] OP_STACK = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_BR_LO = 4'h2;
  localparam logic [3:0] OP_BR_HI = 4'hA;
  localparam logic [3:0] OP_CALL  = 4'hB;
  localparam logic [3:0] OP_RET   = 4'hC;

  localparam int MS_PC_LO = 0;
  localparam int MS_PC_HI = 2;
  localparam int MS_SPDEC = 3;
  localparam int MS_POP   = 4;
  localparam int MS_PUSH  = 5;

  typedef struct packed {
    logic       sp_dec;
    logic       sp_inc;
    logic       xfer;
    logic       reg_write;
    logic       mem_write;
    logic [2:0] fsel;
    logic [5:0] mux_sel;
    logic [3:0] dsel;
  } ctl_t;

endpackage

// File: rtl/stack_pipe_controller_decode.sv
// Combinational decode of one instruction word plus branch condition
// into the control bundle consumed by the EX register.
module instr_decode
  import stack_pipe_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        dcond,
  output ctl_t        ctl
);

  logic [3:0] op;
  logic is_push, is_pop, is_alu;
  logic is_br, is_call, is_ret;
  logic unused_bits;

  assign op          = instr[15:12];
  assign unused_bits = ^instr[9:0];

  always_comb begin
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_alu  = 1'b0;
    is_br   = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    unique case (1'b1)
      (op == OP_STACK): begin
        is_push = ~instr[10];
        is_pop  = instr[10];
      end
      (op == OP_ALU): is_alu = 1'b1;
      (op >= OP_BR_LO && op <= OP_BR_HI):
        is_br = 1'b1;
      (op == OP_CALL): is_call = 1'b1;
      (op == OP_RET):  is_ret  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ctl           = '0;
    ctl.sp_dec    = is_push | is_call;
    ctl.sp_inc    = is_pop | is_ret;
    ctl.xfer      = is_call | is_ret
                  | (is_br & dcond);
    ctl.reg_write = is_pop | is_alu;
    ctl.mem_write = is_push | is_call;
    ctl.fsel[2]   = is_push | is_call;
    ctl.fsel[1:0] = (is_br | is_call)
                  ? 2'b00 : instr[11:10];
    ctl.mux_sel[MS_PC_HI:MS_PC_LO] = {3{ctl.xfer}};
    ctl.mux_sel[MS_SPDEC] = ctl.fsel[2];
    ctl.mux_sel[MS_POP]   = is_pop | is_ret;
    ctl.mux_sel[MS_PUSH]  = is_push;
    ctl.dsel      = op;
  end

endmodule

// File: rtl/stack_pipe_controller.sv
// Two-stage (ID/EX) stack-machine controller: owns the stack pointer,
// sticky overflow/underflow faults and wrong-path squash on redirect.
module stack_pipe_controller
  import stack_pipe_pkg::*;
#(
  parameter int              SP_W    = 8,
  parameter logic [SP_W-1:0] SP_INIT = {SP_W{1'b1}},
  parameter logic [SP_W-1:0] SP_MIN  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  input  logic            dcond,
  input  logic            stall_in,
  output logic            ctl_valid,
  output logic            reg_write,
  output logic            mem_write,
  output logic [5:0]      mux_sel,
  output logic [2:0]      fsel,
  output logic [3:0]      dsel,
  output logic [SP_W-1:0] sp,
  output logic [SP_W-1:0] mem_addr,
  output logic            redirect,
  output logic            fault_ovf,
  output logic            fault_unf
);

  logic        id_valid;
  logic [15:0] id_instr;
  ctl_t        dec;
  logic        ovf, unf, flush;
  logic        do_dec, do_inc;
  logic [SP_W-1:0] addr_nxt;

  instr_decode u_dec (
    .instr (id_instr),
    .dcond (dcond),
    .ctl   (dec)
  );

  assign instr_ready = ~stall_in;

  assign ovf    = id_valid & dec.sp_dec
                & (sp == SP_MIN);
  assign unf    = id_valid & dec.sp_inc
                & (sp == SP_INIT);
  assign do_dec = id_valid & dec.sp_dec & ~ovf;
  assign do_inc = id_valid & dec.sp_inc & ~unf;
  assign flush  = id_valid & dec.xfer;

  always_comb begin
    addr_nxt = '0;
    if (id_valid && dec.sp_dec)
      addr_nxt = sp - SP_W'(1);
    else if (id_valid && dec.sp_inc)
      addr_nxt = sp;
  end

  // ID stage: wrong-path capture is dropped when EX redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (!stall_in) begin
      id_valid <= instr_valid & ~flush;
      if (instr_valid)
        id_instr <= instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      mux_sel   <= '0;
      fsel      <= '0;
      dsel      <= '0;
      redirect  <= 1'b0;
      mem_addr  <= '0;
      sp        <= SP_INIT;
      fault_ovf <= 1'b0;
      fault_unf <= 1'b0;
    end else if (!stall_in) begin
      ctl_valid <= id_valid;
      reg_write <= id_valid & dec.reg_write & ~unf;
      mem_write <= id_valid & dec.mem_write & ~ovf;
      mux_sel   <= id_valid ? dec.mux_sel : '0;
      fsel      <= dec.fsel;
      dsel      <= dec.dsel;
      redirect  <= flush;
      mem_addr  <= addr_nxt;
      if (do_dec)
        sp <= sp - SP_W'(1);
      else if (do_inc)
        sp <= sp + SP_W'(1);
      fault_ovf <= fault_ovf | ovf;
      fault_unf <= fault_unf | unf;
    end
  end

endmodule

// File: tb/tb_stack_pipe_controller.sv
// Directed bench: default 8-bit controller plus a 2-bit-SP instance
// fed the same stream to reach the full-stack condition quickly.
module tb_stack_pipe_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        dcond = 1'b0;
  logic        stall_in = 1'b0;

  logic       instr_ready, ctl_valid, reg_write, mem_write;
  logic [5:0] mux_sel;
  logic [2:0] fsel;
  logic [3:0] dsel;
  logic [7:0] sp, mem_addr;
  logic       redirect, fault_ovf, fault_unf;

  logic       s_ready, s_valid, s_rw, s_mw;
  logic [5:0] s_mux;
  logic [2:0] s_fsel;
  logic [3:0] s_dsel;
  logic [1:0] s_sp, s_addr;
  logic       s_redir, s_ovf, s_unf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_pipe_controller dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr), .dcond(dcond),
    .stall_in(stall_in),
    .ctl_valid(ctl_valid),
    .reg_write(reg_write),
    .mem_write(mem_write),
    .mux_sel(mux_sel), .fsel(fsel),
    .dsel(dsel), .sp(sp),
    .mem_addr(mem_addr),
    .redirect(redirect),
    .fault_ovf(fault_ovf),
    .fault_unf(fault_unf)
  );

  stack_pipe_controller #(.SP_W(2)) u_small (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid),
    .instr_ready(s_ready),
    .instr(instr), .dcond(dcond),
    .stall_in(stall_in),
    .ctl_valid(s_valid),
    .reg_write(s_rw),
    .mem_write(s_mw),
    .mux_sel(s_mux), .fsel(s_fsel),
    .dsel(s_dsel), .sp(s_sp),
    .mem_addr(s_addr),
    .redirect(s_redir),
    .fault_ovf(s_ovf),
    .fault_unf(s_unf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Present (v, ins) and the branch condition for the ID occupant,
  // clock once, return at the following falling edge.
  task automatic step(input logic v,
                      input logic [15:0] ins,
                      input logic dc,
                      input logic st);
    instr_valid = v;
    instr       = ins;
    dcond       = dc;
    stall_in    = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", ctl_valid, 0);
    chk("rst_sp", sp, 8'hFF);
    chk("rst_mux", mux_sel, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dsel", dsel, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_small_sp", s_sp, 2'h3);
    rst = 1'b0;

    // ALU with instr[11:10]=11
    step(1, 16'h1C00, 0, 0);
    chk("alu_lat_valid", ctl_valid, 0);
    step(0, 16'h0, 0, 0);
    chk("alu_valid", ctl_valid, 1);
    chk("alu_rw", reg_write, 1);
    chk("alu_mw", mem_write, 0);
    chk("alu_fsel", fsel, 3'b011);
    chk("alu_mux", mux_sel, 0);
    chk("alu_dsel", dsel, 4'h1);
    chk("alu_sp", sp, 8'hFF);
    step(0, 16'h0, 0, 0);
    chk("idle_valid", ctl_valid, 0);
    chk("idle_rw", reg_write, 0);

    // four back-to-back pushes
    step(1, 16'h0000, 0, 0);
    step(1, 16'h0000, 0, 0);
    chk("push1_addr", mem_addr, 8'hFE);
    chk("push1_mw", mem_write, 1);
    chk("push1_sp", sp, 8'hFE);
    chk("push1_fsel", fsel, 3'b100);
    chk("push1_mux", mux_sel, 6'b101000);
    chk("s_push1_sp", s_sp, 2'h2);
    step(1, 16'h0000, 0, 0);
    chk("push2_addr", mem_addr, 8'hFD);
    chk("push2_mw", mem_write, 1);
    chk("s_push2_sp", s_sp, 2'h1);
    step(1, 16'h0000, 0, 0);
    chk("push3_addr", mem_addr, 8'hFC);
    chk("push3_sp", sp, 8'hFC);
    chk("push3_mw", mem_write, 1);
    chk("s_push3_sp", s_sp, 2'h0);
    chk("s_push3_mw", s_mw, 1);
    chk("s_push3_ovf", s_ovf, 0);
    step(0, 16'h0, 0, 0);
    chk("push4_addr", mem_addr, 8'hFB);
    chk("push4_sp", sp, 8'hFB);
    chk("push4_ovf", fault_ovf, 0);
    chk("s_push4_ovf", s_ovf, 1);
    chk("s_push4_mw", s_mw, 0);
    chk("s_push4_sp", s_sp, 2'h0);
    chk("s_push4_valid", s_valid, 1);
    step(0, 16'h0, 0, 0);
    chk("s_ovf_sticky", s_ovf, 1);

    // push then pop hits the same slot
    do_reset();
    chk("rst2_ovf", s_ovf, 0);
    chk("rst2_sp", sp, 8'hFF);
    step(1, 16'h0000, 0, 0);
    step(1, 16'h0400, 0, 0);
    chk("pp_push_addr", mem_addr, 8'hFE);
    step(0, 16'h0, 0, 0);
    chk("pp_pop_addr", mem_addr, 8'hFE);
    chk("pp_pop_rw", reg_write, 1);
    chk("pp_pop_mw", mem_write, 0);
    chk("pp_pop_mux", mux_sel, 6'b010000);
    chk("pp_pop_fsel", fsel, 3'b001);
    chk("pp_pop_sp", sp, 8'hFF);

    // taken branch squashes the following ALU
    step(1, 16'h4000, 0, 0);
    step(1, 16'h1C00, 1, 0);
    chk("brt_redir", redirect, 1);
    chk("brt_mux", mux_sel, 6'b000111);
    chk("brt_fsel", fsel, 3'b000);
    chk("brt_rw", reg_write, 0);
    chk("brt_dsel", dsel, 4'h4);
    step(0, 16'h0, 0, 0);
    chk("brt_sq_valid", ctl_valid, 0);
    chk("brt_sq_rw", reg_write, 0);
    chk("brt_sq_redir", redirect, 0);

    // not-taken branch lets the ALU through
    step(1, 16'h4000, 0, 0);
    step(1, 16'h1C00, 0, 0);
    chk("brn_valid", ctl_valid, 1);
    chk("brn_redir", redirect, 0);
    chk("brn_mux", mux_sel, 0);
    step(0, 16'h0, 0, 0);
    chk("brn_alu_valid", ctl_valid, 1);
    chk("brn_alu_rw", reg_write, 1);
    chk("brn_alu_fsel", fsel, 3'b011);

    // pop on empty stack
    do_reset();
    step(1, 16'h0400, 0, 0);
    step(0, 16'h0, 0, 0);
    chk("unf_valid", ctl_valid, 1);
    chk("unf_flag", fault_unf, 1);
    chk("unf_rw", reg_write, 0);
    chk("unf_sp", sp, 8'hFF);
    step(0, 16'h0, 0, 0);
    chk("unf_sticky", fault_unf, 1);

    // call, then stall three cycles, then async reset mid-stall
    do_reset();
    chk("rst3_unf", fault_unf, 0);
    step(1, 16'hB000, 0, 0);
    step(0, 16'h0, 0, 0);
    chk("call_redir", redirect, 1);
    chk("call_mw", mem_write, 1);
    chk("call_addr", mem_addr, 8'hFE);
    chk("call_sp", sp, 8'hFE);
    chk("call_mux", mux_sel, 6'b001111);
    chk("call_fsel", fsel, 3'b100);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h1C00, 0, 1);
      chk("stall_ready", instr_ready, 0);
      chk("stall_valid", ctl_valid, 1);
      chk("stall_redir", redirect, 1);
      chk("stall_mw", mem_write, 1);
      chk("stall_sp", sp, 8'hFE);
      chk("stall_addr", mem_addr, 8'hFE);
    end
    rst = 1'b1;
    #1;
    chk("arst_valid", ctl_valid, 0);
    chk("arst_redir", redirect, 0);
    chk("arst_mw", mem_write, 0);
    chk("arst_mux", mux_sel, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_sp", sp, 8'hFF);
    rst = 1'b0;
    step(1, 16'h1C00, 0, 0);
    step(0, 16'h0, 0, 0);
    chk("post_valid", ctl_valid, 1);
    chk("post_rw", reg_write, 1);
    chk("post_sp", sp, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
